// File: rtl/bn_backward_mc_pkg.sv
// Shared types, widths and saturation helpers for the batch-norm backward engine.
package bn_pkg;
  localparam int IL   = 8;
  localparam int FL   = 12;
  localparam int SIZE = 16;
  localparam int CH   = 4;
  localparam int W    = $clog2(SIZE);
  localparam int DW   = IL + FL;
  localparam int PW   = 2 * DW;
  localparam int AW   = DW + W + 1;
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;

  typedef logic signed [DW-1:0] fxp_t;
  typedef logic signed [AW-1:0] acc_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic [W:0]           cnt_t;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
  typedef enum logic [1:0] {ACC, COEF, DX} phase_t;

  localparam prod_t FXP_MAX = prod_t'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam prod_t FXP_MIN = -FXP_MAX - prod_t'(1);
  localparam prod_t ACC_MAX = prod_t'((64'sd1 <<< (AW - 1)) - 64'sd1);
  localparam prod_t ACC_MIN = -ACC_MAX - prod_t'(1);

  function automatic fxp_t sat_fxp(input prod_t x);
    if (x > FXP_MAX) return fxp_t'(FXP_MAX);
    if (x < FXP_MIN) return fxp_t'(FXP_MIN);
    return fxp_t'(x);
  endfunction

  function automatic acc_t sat_acc(input prod_t x);
    if (x > ACC_MAX) return acc_t'(ACC_MAX);
    if (x < ACC_MIN) return acc_t'(ACC_MIN);
    return acc_t'(x);
  endfunction
endpackage

// File: rtl/bn_backward_mc_if.sv
// Job/result bus between a training controller (master) and the engine (slave).
interface bn_backward_mc_if;
  import bn_pkg::*;

  logic input_ready;
  logic output_taken;
  cnt_t num;
  logic skip_dx;
  fxp_t dout    [CH][SIZE];
  fxp_t norm    [CH][SIZE];
  fxp_t gamma   [CH];
  fxp_t inv_std [CH];
  fxp_t dX      [CH][SIZE];
  fxp_t dgamma  [CH];
  fxp_t dbeta   [CH];
  logic [1:0] state;
  logic done;

  modport master (
    output input_ready, output_taken, num, skip_dx, dout, norm, gamma, inv_std,
    input  dX, dgamma, dbeta, state, done
  );

  modport slave (
    input  input_ready, output_taken, num, skip_dx, dout, norm, gamma, inv_std,
    output dX, dgamma, dbeta, state, done
  );
endinterface

// File: rtl/bn_backward_mc_fxp_mac_sat.sv
// Shared multiply / shift / accumulate-or-load unit with saturated result.
// The shifted product and the running sum are both clamped to the accumulator
// range, so a large positive or negative sum pins at the rail instead of wrapping.
module fxp_mac_sat
  import bn_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  fxp_t a,
  input  fxp_t b,
  output acc_t acc,
  output fxp_t res_sat
);
  prod_t prod;
  prod_t term;
  prod_t sum;
  acc_t  acc_next;

  // Product, floor shift, clamp, then either start a new sum or extend the old one.
  always_comb begin
    prod     = prod_t'(a) * prod_t'(b);
    term     = prod >>> FL;
    sum      = load ? prod_t'(sat_acc(term)) : prod_t'(acc) + prod_t'(sat_acc(term));
    acc_next = sat_acc(sum);
    res_sat  = sat_fxp(prod_t'(acc_next));
  end

  // Accumulator register; held while the engine is in the coefficient cycle.
  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else if (en) acc <= acc_next;
  end
endmodule

// File: rtl/bn_backward_mc.sv
// Sequential batch-norm backward engine: per channel, accumulate dgamma/dbeta,
// form the shared coefficient, then produce dX one element per cycle.
module bn_backward_mc
  import bn_pkg::*;
(
  input logic clk,
  input logic reset,
  bn_backward_mc_if.slave bus
);
  state_t          state;
  logic            done_r;
  phase_t          phase;
  logic [CW-1:0]   ch;
  logic [W-1:0]    k;
  cnt_t            num_eff;
  logic            skip_r;
  fxp_t            coef_r;
  acc_t            dbeta_acc;
  fxp_t            dout_r    [CH][SIZE];
  fxp_t            norm_r    [CH][SIZE];
  fxp_t            gamma_r   [CH];
  fxp_t            inv_std_r [CH];
  fxp_t            dx_r      [CH][SIZE];
  fxp_t            dgamma_r  [CH];
  fxp_t            dbeta_r   [CH];

  fxp_t  cur_dout, cur_norm, coef_calc, diff, mac_a, mac_b, mac_res;
  prod_t gi, divisor, ng;
  acc_t  mac_acc;
  logic  mac_en, mac_load, k_last, ch_last;
  cnt_t  num_clip;

  // Operand selection and the per-element dX difference term.
  always_comb begin
    cur_dout  = dout_r[ch][k];
    cur_norm  = norm_r[ch][k];
    num_clip  = (bus.num > cnt_t'(SIZE)) ? cnt_t'(SIZE) : bus.num;
    k_last    = ({1'b0, k} == num_eff - cnt_t'(1));
    ch_last   = (ch == CW'(CH - 1));
    gi        = (prod_t'(gamma_r[ch]) * prod_t'(inv_std_r[ch])) >>> FL;
    divisor   = (num_eff == '0) ? prod_t'(1) : prod_t'(num_eff);
    coef_calc = sat_fxp(gi / divisor);
    ng        = (prod_t'(cur_norm) * prod_t'(dgamma_r[ch])) >>> FL;
    // MAC operands are word-sized, so the difference is clamped to the word range.
    diff      = sat_fxp(prod_t'(num_eff) * prod_t'(cur_dout) - prod_t'(dbeta_r[ch]) - ng);
    mac_en    = (state == BUSY) && (phase != COEF);
    mac_load  = (phase == DX) || (k == '0);
    mac_a     = (phase == DX) ? coef_r : cur_dout;
    mac_b     = (phase == DX) ? diff : cur_norm;
  end

  fxp_mac_sat u_mac (
    .clk     (clk),
    .reset   (reset),
    .en      (mac_en),
    .load    (mac_load),
    .a       (mac_a),
    .b       (mac_b),
    .acc     (mac_acc),
    .res_sat (mac_res)
  );

  // Job FSM: accept/clear in IDLE, ACC -> COEF -> DX per channel in BUSY, hold in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done_r    <= 1'b0;
      phase     <= ACC;
      ch        <= '0;
      k         <= '0;
      num_eff   <= '0;
      skip_r    <= 1'b0;
      coef_r    <= '0;
      dbeta_acc <= '0;
      for (int c = 0; c < CH; c++) begin
        gamma_r[c]   <= '0;
        inv_std_r[c] <= '0;
        dgamma_r[c]  <= '0;
        dbeta_r[c]   <= '0;
        for (int e = 0; e < SIZE; e++) begin
          dout_r[c][e] <= '0;
          norm_r[c][e] <= '0;
          dx_r[c][e]   <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: if (bus.input_ready) begin
          dout_r    <= bus.dout;
          norm_r    <= bus.norm;
          gamma_r   <= bus.gamma;
          inv_std_r <= bus.inv_std;
          skip_r    <= bus.skip_dx;
          num_eff   <= num_clip;
          for (int c = 0; c < CH; c++) begin
            dgamma_r[c] <= '0;
            dbeta_r[c]  <= '0;
            for (int e = 0; e < SIZE; e++) dx_r[c][e] <= '0;
          end
          phase     <= ACC;
          ch        <= '0;
          k         <= '0;
          coef_r    <= '0;
          dbeta_acc <= '0;
          state     <= BUSY;
        end
        BUSY: if (num_eff == '0) begin
          state  <= DONE;
          done_r <= 1'b1;
        end else begin
          case (phase)
            ACC: begin
              dbeta_acc <= (k == '0) ? acc_t'(cur_dout) : dbeta_acc + acc_t'(cur_dout);
              if (k_last) begin
                k     <= '0;
                phase <= COEF;
              end else begin
                k <= k + 1'b1;
              end
            end
            COEF: begin
              dgamma_r[ch] <= sat_fxp(prod_t'(mac_acc));
              dbeta_r[ch]  <= sat_fxp(prod_t'(dbeta_acc));
              coef_r       <= coef_calc;
              if (!skip_r) begin
                phase <= DX;
              end else if (ch_last) begin
                state  <= DONE;
                done_r <= 1'b1;
              end else begin
                ch    <= ch + 1'b1;
                phase <= ACC;
              end
            end
            DX: begin
              dx_r[ch][k] <= mac_res;
              if (k_last) begin
                k <= '0;
                if (ch_last) begin
                  state  <= DONE;
                  done_r <= 1'b1;
                end else begin
                  ch    <= ch + 1'b1;
                  phase <= ACC;
                end
              end else begin
                k <= k + 1'b1;
              end
            end
            default: phase <= ACC;
          endcase
        end
        DONE: if (bus.output_taken) begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state  = state;
  assign bus.done   = done_r;
  assign bus.dX     = dx_r;
  assign bus.dgamma = dgamma_r;
  assign bus.dbeta  = dbeta_r;
endmodule
